// File: rtl/keypad_lock_ctrl_pkg.sv
// Shared types and constants for the keypad lock controller.
// Scanner and lock FSM states, 4x4 key codes, key-code width helper.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_CHECK,
        ST_OPEN,
        ST_LOCKOUT
    } lock_state_t;

    typedef enum logic [1:0] {
        SC_SCAN,
        SC_PRESS_DB,
        SC_HELD,
        SC_RELEASE_DB
    } scan_state_t;

    // 4x4 layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    localparam int KEY_STAR = 12;
    localparam int KEY_HASH = 14;

    function automatic int key_w(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

endpackage

// File: rtl/keypad_lock_ctrl_if.sv
// Pin-side and door-side signal bundle of the keypad lock controller.
// master drives keypad rows and controls; slave is the controller.
interface keypad_lock_ctrl_if
    import keypad_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int MAX_FAILS = 3
);
    localparam int KW = key_w(ROWS, COLS);
    localparam int FW = $clog2(MAX_FAILS + 1);

    logic            en;
    logic [ROWS-1:0] row;
    logic            relock;
    logic            prog_mode;
    logic [COLS-1:0] col;
    logic            key_valid;
    logic [KW-1:0]   key_code;
    logic            access_granted;
    logic            access_denied;
    logic            locked;
    logic            code_updated;
    logic [FW-1:0]   fail_cnt;

    modport master (
        output en, row, relock, prog_mode,
        input  col, key_valid, key_code, access_granted,
        input  access_denied, locked, code_updated, fail_cnt
    );

    modport slave (
        input  en, row, relock, prog_mode,
        output col, key_valid, key_code, access_granted,
        output access_denied, locked, code_updated, fail_cnt
    );

endinterface

// File: rtl/keypad_lock_ctrl_scanner.sv
// Column scanner with press/release debounce for a ROWS x COLS keypad.
// Emits one key_valid pulse per debounced press; code held afterwards.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int DEBOUNCE_CYC = 4,
    localparam int KW          = key_w(ROWS, COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic            key_valid,
    output logic [KW-1:0]   key_code
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    scan_state_t     st;
    logic [ROWS-1:0] pat;
    logic [CW-1:0]   cnt;
    logic [KW-1:0]   code_now;
    logic [COLS-1:0] col_rot;
    logic            db_done;

    assign col_rot = {col[COLS-2:0], col[COLS-1]};
    // cnt holds stable cycles already seen; this cycle completes the run
    assign db_done = (int'(cnt) + 1 >= DEBOUNCE_CYC);

    // Encode the active row and the driven column into a key code
    always_comb begin
        int ri;
        int ci;
        ri = 0;
        ci = 0;
        for (int i = 0; i < ROWS; i++)
            if (row[i]) ri = i;
        for (int j = 0; j < COLS; j++)
            if (col[j]) ci = j;
        code_now = KW'(ri * COLS + ci);
    end

    // Scan / debounce state machine with registered key outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= SC_SCAN;
            col       <= COLS'(1);
            pat       <= '0;
            cnt       <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            key_valid <= 1'b0;
            if (en) begin
                unique case (st)
                    SC_SCAN: begin
                        if ($onehot(row)) begin
                            pat <= row;
                            cnt <= CW'(1);
                            if (DEBOUNCE_CYC == 1) begin
                                key_valid <= 1'b1;
                                key_code  <= code_now;
                                st        <= SC_HELD;
                            end else begin
                                st <= SC_PRESS_DB;
                            end
                        end else begin
                            col <= col_rot;
                        end
                    end
                    SC_PRESS_DB: begin
                        if (row != pat) begin
                            st <= SC_SCAN;
                        end else if (db_done) begin
                            key_valid <= 1'b1;
                            key_code  <= code_now;
                            st        <= SC_HELD;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    SC_HELD: begin
                        if (row == '0) begin
                            cnt <= CW'(1);
                            if (DEBOUNCE_CYC == 1) begin
                                st  <= SC_SCAN;
                                col <= col_rot;
                            end else begin
                                st <= SC_RELEASE_DB;
                            end
                        end
                    end
                    SC_RELEASE_DB: begin
                        if (row != '0) begin
                            st <= SC_HELD;
                        end else if (db_done) begin
                            st  <= SC_SCAN;
                            col <= col_rot;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad lock: code entry, compare, fail counting, lockout and reprogram.
// Scanner feeds keys; lock FSM owns buffer, stored code and counters.
module keypad_lock_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int CODE_LEN     = 4,
    parameter int DEBOUNCE_CYC = 4,
    parameter int MAX_FAILS    = 3,
    parameter int LOCKOUT_CYC  = 1024,
    parameter int CLR_KEY      = KEY_STAR,
    parameter logic [CODE_LEN*key_w(ROWS, COLS)-1:0]
        DEFAULT_CODE = 16'h5690
) (
    input logic              clk,
    input logic              rst,
    keypad_lock_ctrl_if.slave bus
);
    localparam int KW  = key_w(ROWS, COLS);
    localparam int FW  = $clog2(MAX_FAILS + 1);
    localparam int IW  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int LCW = $clog2(LOCKOUT_CYC + 1);

    logic          kv;
    logic [KW-1:0] kc;

    keypad_scanner #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .en        (bus.en),
        .row       (bus.row),
        .col       (bus.col),
        .key_valid (kv),
        .key_code  (kc)
    );

    lock_state_t                 st;
    logic [CODE_LEN-1:0][KW-1:0] buf_q;
    logic [CODE_LEN-1:0][KW-1:0] buf_nxt;
    logic [CODE_LEN*KW-1:0]      stored;
    logic [IW-1:0]               idx;
    logic [LCW-1:0]              lock_cnt;
    logic [FW-1:0]               fail_q;
    logic                        granted_q;
    logic                        denied_q;
    logic                        locked_q;
    logic                        upd_q;
    logic                        is_clr;
    logic                        is_last;

    assign is_clr  = (kc == KW'(CLR_KEY));
    assign is_last = (idx == IW'(CODE_LEN - 1));

    // Buffer contents with the incoming key written at the current slot
    always_comb begin
        buf_nxt      = buf_q;
        buf_nxt[idx] = kc;
    end

    // Lock FSM: entry, one-cycle compare, open/program, timed lockout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= ST_ENTRY;
            buf_q     <= '0;
            stored    <= DEFAULT_CODE;
            idx       <= '0;
            lock_cnt  <= '0;
            fail_q    <= '0;
            granted_q <= 1'b0;
            denied_q  <= 1'b0;
            locked_q  <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            denied_q <= 1'b0;
            upd_q    <= 1'b0;
            if (bus.en) begin
                unique case (st)
                    ST_ENTRY: begin
                        if (kv) begin
                            if (is_clr) begin
                                idx <= '0;
                            end else begin
                                buf_q <= buf_nxt;
                                if (is_last) begin
                                    idx <= '0;
                                    st  <= ST_CHECK;
                                end else begin
                                    idx <= idx + IW'(1);
                                end
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (buf_q == stored) begin
                            st        <= ST_OPEN;
                            granted_q <= 1'b1;
                            fail_q    <= '0;
                        end else begin
                            denied_q <= 1'b1;
                            if (fail_q != FW'(MAX_FAILS))
                                fail_q <= fail_q + FW'(1);
                            if (int'(fail_q) + 1 >= MAX_FAILS) begin
                                st       <= ST_LOCKOUT;
                                locked_q <= 1'b1;
                                lock_cnt <= '0;
                            end else begin
                                st <= ST_ENTRY;
                            end
                        end
                    end
                    ST_OPEN: begin
                        if (bus.relock) begin
                            st        <= ST_ENTRY;
                            granted_q <= 1'b0;
                            idx       <= '0;
                        end else if (kv && bus.prog_mode) begin
                            if (is_clr) begin
                                idx <= '0;
                            end else begin
                                buf_q <= buf_nxt;
                                if (is_last) begin
                                    stored <= buf_nxt;
                                    upd_q  <= 1'b1;
                                    idx    <= '0;
                                end else begin
                                    idx <= idx + IW'(1);
                                end
                            end
                        end
                    end
                    ST_LOCKOUT: begin
                        if (lock_cnt == LCW'(LOCKOUT_CYC - 1)) begin
                            st       <= ST_ENTRY;
                            locked_q <= 1'b0;
                            fail_q   <= '0;
                            idx      <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + LCW'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign bus.key_valid      = kv;
    assign bus.key_code       = kc;
    assign bus.access_granted = granted_q;
    assign bus.access_denied  = denied_q;
    assign bus.locked         = locked_q;
    assign bus.code_updated   = upd_q;
    assign bus.fail_cnt       = fail_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Testbench for keypad_lock_ctrl: directed and random key sequences.
// A queue-based lock model predicts grants, denials, updates and lockout.
module tb_keypad_lock_ctrl;
    import keypad_pkg::*;

    localparam int DB   = 4;
    localparam int LOCK = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keypad_lock_ctrl_if #(.ROWS(4), .COLS(4), .MAX_FAILS(3)) ifc ();

    keypad_lock_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Keypad model: a held key connects its row when its column is driven
    logic [3:0] hk = 4'd0;
    bit         held = 1'b0;
    logic [3:0] row_drv;
    always_comb begin
        row_drv = 4'b0;
        if (held && ifc.col[hk[1:0]]) row_drv = 4'b1 << hk[3:2];
    end
    assign ifc.row = row_drv;

    int cyc = 0;
    int checks = 0;
    int passes = 0;
    int kv_n = 0, kv_last = -1, kv_code = -1, first_row = -1;
    int n_deny = 0, n_grant = 0, n_upd = 0, n_lock = 0;
    int deny_cyc = -1, grant_cyc = -1, upd_cyc = -1;
    int lock_cyc = -1, unlock_cyc = -1;
    bit prev_g = 1'b0, prev_l = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle in which the keypad row first becomes visible to the DUT
    always @(posedge clk)
        if (ifc.row != 4'b0 && first_row < 0) first_row = cyc;

    // Event recorder sampled mid-cycle
    always @(negedge clk) begin
        if (ifc.key_valid) begin
            kv_n++;
            kv_last = cyc;
            kv_code = int'(ifc.key_code);
        end
        if (ifc.access_denied) begin n_deny++; deny_cyc = cyc; end
        if (ifc.code_updated) begin n_upd++; upd_cyc = cyc; end
        if (ifc.access_granted && !prev_g) begin
            n_grant++;
            grant_cyc = cyc;
        end
        if (ifc.locked && !prev_l) begin n_lock++; lock_cyc = cyc; end
        if (!ifc.locked && prev_l) unlock_cyc = cyc;
        prev_g = ifc.access_granted;
        prev_l = ifc.locked;
    end

    // Behavioural lock model
    int m_code[4];
    int m_buf[$];
    bit m_open, m_lock;
    int m_fails, m_lock_end;
    int m_deny_n, m_grant_n, m_upd_n, m_lock_n;
    int e_deny, e_grant, e_upd, e_lock;

    function automatic void m_reset();
        m_code = '{0, 9, 6, 5};
        m_buf.delete();
        m_open = 0; m_lock = 0; m_fails = 0; m_lock_end = 0;
        m_deny_n = 0; m_grant_n = 0; m_upd_n = 0; m_lock_n = 0;
    endfunction

    function automatic void m_sync(input int now);
        if (m_lock && now >= m_lock_end) begin
            m_lock  = 0;
            m_fails = 0;
        end
    endfunction

    function automatic void m_key(input int k, input int t, input bit prog);
        bit match;
        m_sync(t);
        if (m_lock) return;
        if (m_open && !prog) return;
        if (k == KEY_STAR) begin
            m_buf.delete();
            return;
        end
        m_buf.push_back(k);
        if (m_buf.size() < 4) return;
        if (m_open) begin
            foreach (m_code[i]) m_code[i] = m_buf[i];
            m_upd_n++;
            e_upd = t + 1;
        end else begin
            match = 1;
            foreach (m_code[i]) if (m_buf[i] != m_code[i]) match = 0;
            if (match) begin
                m_open = 1; m_fails = 0;
                m_grant_n++; e_grant = t + 2;
            end else begin
                m_fails++;
                m_deny_n++; e_deny = t + 2;
                if (m_fails >= 3) begin
                    m_lock = 1; m_lock_n++;
                    e_lock = t + 2;
                    m_lock_end = t + 2 + LOCK;
                end
            end
        end
        m_buf.delete();
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic m_check();
        m_sync(cyc);
        check("granted", ifc.access_granted, m_open);
        check("locked", ifc.locked, m_lock);
        check("fail_cnt", ifc.fail_cnt, m_fails);
        check("n_deny", n_deny, m_deny_n);
        check("n_grant", n_grant, m_grant_n);
        check("n_upd", n_upd, m_upd_n);
        check("n_lock", n_lock, m_lock_n);
        if (m_deny_n > 0) check("deny_cyc", deny_cyc, e_deny);
        if (m_grant_n > 0) check("grant_cyc", grant_cyc, e_grant);
        if (m_upd_n > 0) check("upd_cyc", upd_cyc, e_upd);
        if (m_lock_n > 0) check("lock_cyc", lock_cyc, e_lock);
    endtask

    task automatic press(input int k, input int hold, input int rel,
                         input bit lat);
        int n0;
        n0 = kv_n;
        first_row = -1;
        hk = 4'(k);
        held = 1'b1;
        repeat (hold) step();
        held = 1'b0;
        repeat (rel) step();
        if (ifc.en) begin
            check("kv_once", kv_n - n0, 1);
            check("kv_code", kv_code, k);
            if (lat) check("kv_latency", kv_last, first_row + DB);
            m_key(k, kv_last, ifc.prog_mode);
        end else begin
            check("kv_frozen", kv_n - n0, 0);
        end
        m_check();
    endtask

    task automatic enter(input int a, input int b, input int c,
                         input int d);
        press(a, 10, 10, 1);
        press(b, 10, 10, 1);
        press(c, 10, 10, 1);
        press(d, 10, 10, 1);
    endtask

    task automatic do_relock();
        ifc.relock = 1'b1;
        step();
        ifc.relock = 1'b0;
        step();
        if (m_open) begin
            m_open = 0;
            m_buf.delete();
        end
        m_check();
    endtask

    task automatic wait_unlock();
        int n;
        n = 0;
        while (ifc.locked && n < 1200) begin
            step();
            n++;
        end
        check("unlock_seen", ifc.locked, 1'b0);
        check("unlock_cyc", unlock_cyc, m_lock_end);
        m_check();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        held = 1'b0;
        step();
        check("rst_col", ifc.col, 4'b0001);
        check("rst_kv", ifc.key_valid, 1'b0);
        check("rst_code", ifc.key_code, 4'd0);
        check("rst_granted", ifc.access_granted, 1'b0);
        check("rst_denied", ifc.access_denied, 1'b0);
        check("rst_locked", ifc.locked, 1'b0);
        check("rst_upd", ifc.code_updated, 1'b0);
        check("rst_fail", ifc.fail_cnt, 2'd0);
        step();
        rst = 1'b0;
        step();
        m_reset();
        n_deny = 0; n_grant = 0; n_upd = 0; n_lock = 0;
    endtask

    initial begin
        int n0;
        ifc.en = 1'b1;
        ifc.relock = 1'b0;
        ifc.prog_mode = 1'b0;
        m_reset();
        step();
        do_reset();

        // Default code grants
        enter(0, 9, 6, 5);
        do_relock();

        // Bouncing press, then a long hold, both on the clear key
        n0 = kv_n;
        hk = 4'd12;
        for (int i = 0; i < 3; i++) begin
            held = (i % 2 == 0);
            step();
        end
        held = 1'b0;
        check("bounce_no_kv", kv_n - n0, 0);
        press(12, 12, 10, 0);
        press(12, 200, 10, 1);

        // Three wrong codes lock out; correct code ignored meanwhile
        repeat (3) enter(0, 9, 6, 4);
        enter(0, 9, 6, 5);
        wait_unlock();
        enter(0, 9, 6, 5);
        do_relock();

        // Clear key restarts entry
        press(0, 10, 10, 1);
        press(9, 10, 10, 1);
        press(12, 10, 10, 1);
        enter(0, 9, 6, 5);

        // Reprogram, relock, old code denied, new code grants
        ifc.prog_mode = 1'b1;
        enter(1, 2, 3, 4);
        ifc.prog_mode = 1'b0;
        do_relock();
        enter(0, 9, 6, 5);
        enter(1, 2, 3, 4);
        do_relock();

        // Partial buffer survives while disabled
        press(1, 10, 10, 1);
        press(2, 10, 10, 1);
        ifc.en = 1'b0;
        press(3, 10, 10, 0);
        ifc.en = 1'b1;
        press(3, 10, 10, 1);
        press(4, 10, 10, 1);
        do_relock();

        // Random attempts against the model
        for (int a = 0; a < 8; a++) begin
            bit good;
            if (m_lock) wait_unlock();
            good = ($urandom_range(0, 1) == 1);
            for (int j = 0; j < 4; j++)
                press(good ? m_code[j] : int'($urandom_range(0, 15)),
                      int'($urandom_range(10, 16)),
                      int'($urandom_range(10, 14)), 1);
            if (m_open) do_relock();
        end
        if (m_lock) wait_unlock();

        // Reset in the middle of a press debounce restores the default code
        hk = 4'd0;
        held = 1'b1;
        for (int i = 0; i < 8 && first_row < 0; i++) step();
        first_row = -1;
        step();
        do_reset();
        enter(0, 9, 6, 5);
        do_relock();

        // Reset during lockout
        repeat (3) enter(7, 7, 7, 7);
        step();
        do_reset();
        enter(0, 9, 6, 5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
